// File: rtl/flag_writer.sv
// NZCV flag writer: derives flags from the ALU result, commits them under gated group enables, keeps one shadow copy.
// Latency 1 cycle (FlagsNext is the zero-latency bypass); Stall holds all state and clears RestoreErr.
module flag_writer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic             ALUCarryOut,
    input  logic             SrcASign,
    input  logic             SrcBSign,
    input  logic             ALUSub,
    input  logic             ALULogic,
    input  logic [1:0]       FlagWrite,
    input  logic             CondEx,
    input  logic             Stall,
    input  logic             Save,
    input  logic             Restore,
    output logic [3:0]       Flags,
    output logic [3:0]       FlagsNext,
    output logic             ShadowValid,
    output logic             RestoreErr
);

    logic [3:0] r_flags;
    logic [3:0] r_shadow;
    logic       r_shadow_valid;
    logic       r_restore_err;

    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;
    logic       w_wr_nz;
    logic       w_wr_cv;
    logic       w_do_restore;
    logic       w_restore_err;
    logic [3:0] w_upd;
    logic [3:0] w_flags_next;

    assign w_n = ALUResult[WIDTH-1];
    assign w_z = (ALUResult == '0);
    assign w_c = ALUCarryOut;
    // SrcBSign is pre-inversion, so subtract overflows when the operand signs differ
    assign w_v = (ALUSub ? (SrcASign != SrcBSign) : (SrcASign == SrcBSign)) & (w_n != SrcASign);

    assign w_wr_nz = FlagWrite[1] & CondEx & ~Stall;
    assign w_wr_cv = FlagWrite[0] & CondEx & ~ALULogic & ~Stall;

    assign w_do_restore  = Restore & r_shadow_valid & ~Stall;
    assign w_restore_err = Restore & ~r_shadow_valid & ~Stall;

    always_comb begin
        w_upd = r_flags;
        if (w_wr_nz) begin
            w_upd[3] = w_n;
            w_upd[2] = w_z;
        end
        if (w_wr_cv) begin
            w_upd[1] = w_c;
            w_upd[0] = w_v;
        end
        w_flags_next = w_do_restore ? r_shadow : w_upd;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flags        <= 4'b0000;
            r_shadow       <= 4'b0000;
            r_shadow_valid <= 1'b0;
            r_restore_err  <= 1'b0;
        end else begin
            r_flags       <= w_flags_next;
            r_restore_err <= w_restore_err;
            if (!Stall) begin
                // Save captures the pre-update flags; with a valid Restore this forms a swap
                if (Save) begin
                    r_shadow       <= r_flags;
                    r_shadow_valid <= 1'b1;
                end else if (w_do_restore) begin
                    r_shadow_valid <= 1'b0;
                end
            end
        end
    end

    assign Flags       = r_flags;
    assign FlagsNext   = w_flags_next;
    assign ShadowValid = r_shadow_valid;
    assign RestoreErr  = r_restore_err;

endmodule

// File: tb/tb_flag_writer.sv
// Directed bench for flag_writer: each scenario task drives vectors and checks against hand-computed values.
module tb_flag_writer;

    logic        clk;
    logic        reset_n;
    logic [31:0] ALUResult;
    logic        ALUCarryOut;
    logic        SrcASign;
    logic        SrcBSign;
    logic        ALUSub;
    logic        ALULogic;
    logic [1:0]  FlagWrite;
    logic        CondEx;
    logic        Stall;
    logic        Save;
    logic        Restore;
    logic [3:0]  Flags;
    logic [3:0]  FlagsNext;
    logic        ShadowValid;
    logic        RestoreErr;

    int n_vec = 0;
    int n_err = 0;

    flag_writer #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .ALUResult(ALUResult), .ALUCarryOut(ALUCarryOut),
        .SrcASign(SrcASign), .SrcBSign(SrcBSign), .ALUSub(ALUSub), .ALULogic(ALULogic),
        .FlagWrite(FlagWrite), .CondEx(CondEx), .Stall(Stall), .Save(Save), .Restore(Restore),
        .Flags(Flags), .FlagsNext(FlagsNext), .ShadowValid(ShadowValid), .RestoreErr(RestoreErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] res, input logic c, input logic as, input logic bs,
                         input logic sub, input logic lg, input logic [1:0] fw, input logic cx,
                         input logic st, input logic sv, input logic rs);
        ALUResult = res; ALUCarryOut = c; SrcASign = as; SrcBSign = bs; ALUSub = sub;
        ALULogic = lg; FlagWrite = fw; CondEx = cx; Stall = st; Save = sv; Restore = rs;
        #1;
    endtask

    task automatic idle();
        drive(32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // arbitrary operand taps giving N=1 Z=0 C=1 V=1
        drive(32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        n_vec++; if (Flags !== 4'b1011) begin n_err++; $display("FAIL reset_setup Flags got %b want %b", Flags, 4'b1011); end
        idle();
        drive(32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        idle();
        #1 reset_n = 1'b0;
        #1;
        n_vec++; if (Flags !== 4'b0000) begin n_err++; $display("FAIL reset_async Flags got %b want %b", Flags, 4'b0000); end
        n_vec++; if (ShadowValid !== 1'b0) begin n_err++; $display("FAIL reset_async ShadowValid got %b want 0", ShadowValid); end
        n_vec++; if (RestoreErr !== 1'b0) begin n_err++; $display("FAIL reset_async RestoreErr got %b want 0", RestoreErr); end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        // 0x7FFFFFFF + 1
        drive(32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (FlagsNext !== 4'b1001) begin n_err++; $display("FAIL reset_add FlagsNext got %b want %b", FlagsNext, 4'b1001); end
        n_vec++; if (Flags !== 4'b0000) begin n_err++; $display("FAIL reset_add pre Flags got %b want %b", Flags, 4'b0000); end
        step();
        n_vec++; if (Flags !== 4'b1001) begin n_err++; $display("FAIL reset_add Flags got %b want %b", Flags, 4'b1001); end
        idle();
    endtask

    task automatic test_sub();
        drive(32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        n_vec++; if (Flags !== 4'b0110) begin n_err++; $display("FAIL sub_5_5 Flags got %b want %b", Flags, 4'b0110); end
        drive(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        n_vec++; if (Flags !== 4'b1000) begin n_err++; $display("FAIL sub_3_5 Flags got %b want %b", Flags, 4'b1000); end
        // signed overflow on subtract: positive minus negative giving negative
        drive(32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        n_vec++; if (Flags !== 4'b1001) begin n_err++; $display("FAIL sub_ovf Flags got %b want %b", Flags, 4'b1001); end
        idle();
    endtask

    task automatic test_gating();
        drive(32'h1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        n_vec++; if (Flags !== 4'b0011) begin n_err++; $display("FAIL gate_setup Flags got %b want %b", Flags, 4'b0011); end
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        n_vec++; if (Flags !== 4'b0111) begin n_err++; $display("FAIL gate_logic_nz Flags got %b want %b", Flags, 4'b0111); end
        drive(32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        n_vec++; if (Flags !== 4'b1011) begin n_err++; $display("FAIL gate_logic_cv Flags got %b want %b", Flags, 4'b1011); end
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        n_vec++; if (Flags !== 4'b1011) begin n_err++; $display("FAIL gate_condex Flags got %b want %b", Flags, 4'b1011); end
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1);
        n_vec++; if (FlagsNext !== 4'b1011) begin n_err++; $display("FAIL gate_stall FlagsNext got %b want %b", FlagsNext, 4'b1011); end
        step();
        n_vec++; if (Flags !== 4'b1011) begin n_err++; $display("FAIL gate_stall Flags got %b want %b", Flags, 4'b1011); end
        n_vec++; if (ShadowValid !== 1'b0) begin n_err++; $display("FAIL gate_stall ShadowValid got %b want 0", ShadowValid); end
        n_vec++; if (RestoreErr !== 1'b0) begin n_err++; $display("FAIL gate_stall RestoreErr got %b want 0", RestoreErr); end
        idle();
    endtask

    task automatic test_save_restore();
        drive(32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        n_vec++; if (Flags !== 4'b1010) begin n_err++; $display("FAIL sr_setup Flags got %b want %b", Flags, 4'b1010); end
        drive(32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        n_vec++; if (ShadowValid !== 1'b1) begin n_err++; $display("FAIL sr_save ShadowValid got %b want 1", ShadowValid); end
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        n_vec++; if (Flags !== 4'b0100) begin n_err++; $display("FAIL sr_add Flags got %b want %b", Flags, 4'b0100); end
        drive(32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
        n_vec++; if (FlagsNext !== 4'b1010) begin n_err++; $display("FAIL sr_restore FlagsNext got %b want %b", FlagsNext, 4'b1010); end
        step();
        n_vec++; if (Flags !== 4'b1010) begin n_err++; $display("FAIL sr_restore Flags got %b want %b", Flags, 4'b1010); end
        n_vec++; if (ShadowValid !== 1'b0) begin n_err++; $display("FAIL sr_restore ShadowValid got %b want 0", ShadowValid); end
        n_vec++; if (RestoreErr !== 1'b0) begin n_err++; $display("FAIL sr_restore RestoreErr got %b want 0", RestoreErr); end
        idle();
    endtask

    task automatic test_error_swap();
        drive(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        n_vec++; if (Flags !== 4'b0110) begin n_err++; $display("FAIL err_restore Flags got %b want %b", Flags, 4'b0110); end
        n_vec++; if (RestoreErr !== 1'b1) begin n_err++; $display("FAIL err_pulse RestoreErr got %b want 1", RestoreErr); end
        idle();
        step();
        n_vec++; if (RestoreErr !== 1'b0) begin n_err++; $display("FAIL err_pulse_end RestoreErr got %b want 0", RestoreErr); end
        // shadow = 0001
        drive(32'h1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive(32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        drive(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        n_vec++; if (Flags !== 4'b1000) begin n_err++; $display("FAIL swap_setup Flags got %b want %b", Flags, 4'b1000); end
        drive(32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        n_vec++; if (Flags !== 4'b0001) begin n_err++; $display("FAIL swap Flags got %b want %b", Flags, 4'b0001); end
        n_vec++; if (ShadowValid !== 1'b1) begin n_err++; $display("FAIL swap ShadowValid got %b want 1", ShadowValid); end
        n_vec++; if (RestoreErr !== 1'b0) begin n_err++; $display("FAIL swap RestoreErr got %b want 0", RestoreErr); end
        drive(32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        n_vec++; if (Flags !== 4'b1000) begin n_err++; $display("FAIL swap_shadow Flags got %b want %b", Flags, 4'b1000); end
        n_vec++; if (ShadowValid !== 1'b0) begin n_err++; $display("FAIL swap_shadow ShadowValid got %b want 0", ShadowValid); end
        // Save+Restore with no valid shadow: save only, plus error pulse
        drive(32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        n_vec++; if (Flags !== 4'b1000) begin n_err++; $display("FAIL saverr Flags got %b want %b", Flags, 4'b1000); end
        n_vec++; if (ShadowValid !== 1'b1) begin n_err++; $display("FAIL saverr ShadowValid got %b want 1", ShadowValid); end
        n_vec++; if (RestoreErr !== 1'b1) begin n_err++; $display("FAIL saverr RestoreErr got %b want 1", RestoreErr); end
        idle();
        step();
        n_vec++; if (RestoreErr !== 1'b0) begin n_err++; $display("FAIL saverr_end RestoreErr got %b want 0", RestoreErr); end
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (Flags !== 4'b0000) begin n_err++; $display("FAIL init_reset Flags got %b want %b", Flags, 4'b0000); end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        test_reset();
        test_sub();
        test_gating();
        test_save_restore();
        test_error_swap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
